// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 87;  // 10 MHz / 115200 baud
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable
// reset value so idle-high lines come out of reset without a false edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments keep the two flops a true two-stage pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is
// defined (which also adds the Parity_Err_out port).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       Rx_Serial_in,
    output logic       Rx_DV_out,
    output logic [7:0] Rx_Byte_out,
    output logic       Frame_Err_out
`ifdef UART_RX_PARITY_EN
    ,
    output logic       Parity_Err_out
`endif
);

    localparam int                HALF     = CLKS_PER_BIT / 2;
    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

    logic                 line_s;
    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [2:0]           idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [7:0]           byte_nxt;
    logic                 dv_nxt, ferr_nxt, par_err;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (RST),
        .d   (Rx_Serial_in),
        .q   (line_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_bit_nxt, perr_nxt;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_err = (^shreg) ^ par_bit;
`else
    assign par_err = 1'b0;
`endif

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        shreg_nxt = shreg;
        byte_nxt  = Rx_Byte_out;
        dv_nxt    = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (!line_s) state_nxt = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    state_nxt = line_s ? IDLE : DATA;  // high at mid-bit: glitch, drop silently
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt        = '0;
                    shreg_nxt[idx] = line_s;
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt     = '0;
                    par_bit_nxt = line_s;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    ferr_nxt  = !line_s;
`ifdef UART_RX_PARITY_EN
                    perr_nxt  = par_err;
`endif
                    if (line_s && !par_err) begin
                        byte_nxt = shreg;
                        dv_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            Rx_Byte_out   <= 8'h00;
            Rx_DV_out     <= 1'b0;
            Frame_Err_out <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit        <= 1'b0;
            Parity_Err_out <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            shreg         <= shreg_nxt;
            Rx_Byte_out   <= byte_nxt;
            Rx_DV_out     <= dv_nxt;
            Frame_Err_out <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit        <= par_bit_nxt;
            Parity_Err_out <= perr_nxt;
`endif
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-byte receiver that sits directly upstream of the decoder in the SHA-256 input path. It oversamples the asynchronous serial line with the system clock and validates the start bit at mid-bit. It deserialises 8 data bits LSB-first and checks the stop bit. Each good frame is presented as a byte with a one-cycle valid strobe, which the decoder consumes as its received byte and data-valid inputs.

## Interface
- CLKS_PER_BIT, default 87 — system clocks per serial bit (10 MHz / 115200 baud); must be ≥ 4.
- clk  input  1  system clock; all logic on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- Rx_Serial_in  input  1  asynchronous serial line; idles high.
- Rx_DV_out  output  1  one-cycle pulse: Rx_Byte_out holds a new valid byte.
- Rx_Byte_out  output  8  last valid received byte; stable between pulses.
- Frame_Err_out  output  1  one-cycle pulse: stop bit sampled low; byte discarded.
- Parity_Err_out  output  1  present only with UART_RX_PARITY_EN; one-cycle pulse on parity mismatch.

## Operation
- Rx_Serial_in passes through a 2-flop synchroniser before any use. Only the second flop (line_s) feeds the FSM.
- HALF = CLKS_PER_BIT/2, using integer division.
- Bit counter width is $clog2(CLKS_PER_BIT). It wraps to 0 on every bit-boundary decision.
- Bit index is 3 bits wide.
- FSM states and transitions:
  - IDLE: counter = 0, index = 0. Go to START when line_s = 0.
  - START: count 0..HALF-1. At HALF-1, go to DATA if line_s = 0; otherwise return to IDLE as a glitch, with no error pulse.
  - DATA: count 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, shift line_s into the internal shift register at position index.
    - If index = 7, go to PARITY when the macro is defined, else to STOP.
    - Otherwise, increment index.
  - PARITY: present only with the macro. Sample at CLKS_PER_BIT-1, then go to STOP.
  - STOP: sample at CLKS_PER_BIT-1, then go to IDLE.
    - If line_s = 1 and there is no parity error: load Rx_Byte_out from the shift register and pulse Rx_DV_out.
    - If line_s = 0: pulse Frame_Err_out only.
- Rx_Byte_out changes only together with a Rx_DV_out pulse. It is never updated on an error frame.
- Frame and parity error checks are both evaluated at the stop sample. Both error pulses may assert in the same cycle. A frame with either error produces no Rx_DV_out pulse.
- Reset values:
  - Rx_Byte_out = 0x00.
  - Rx_DV_out = 0, Frame_Err_out = 0, Parity_Err_out = 0.
  - Both synchroniser flops = 1.
  - State = IDLE; counter, index and shift register = 0.
- RST asserted mid-frame aborts the frame with no pulse. Reception restarts from IDLE and waits for a fresh falling edge.

## Timing
- Edge numbering: edge 0 is the first clock edge at which the synchroniser's first flop captures Rx_Serial_in = 0.
- START is entered at edge 2. The start-bit check happens at edge 2+HALF.
- Data bit k is sampled at edge 2+HALF+(k+1)·CLKS_PER_BIT.
- The stop sample is at edge 2+HALF+9·CLKS_PER_BIT, or +10·CLKS_PER_BIT with parity.
- Rx_DV_out and the error pulses are registered. They are high for exactly the one cycle after the stop-sample edge.
- Back-to-back frames with no idle gap are received without loss. IDLE is re-entered half a stop bit before the next start edge.
- Because Rx_DV_out is one cycle wide, the downstream stage must accept it unconditionally. There is no backpressure.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is start + 8 data + even parity + stop.
  - The PARITY state exists.
  - Parity_Err_out is a port and pulses when the XOR of the 8 data bits and the parity bit is 1.
- UART_RX_PARITY_EN undefined: frame is 8N1, with no PARITY state and no Parity_Err_out port.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the default CLKS_PER_BIT constant;
  - the data-bit count constant 8.
- One sub-module, sync_2ff: a 2-flop synchroniser with a reset value parameter, instantiated with reset value 1.

## Test plan
Use CLKS_PER_BIT = 16 (HALF = 8) for all scenarios.
- Send 0xA5 in 8N1 → Rx_DV_out high for one cycle after edge 154, Rx_Byte_out = 0xA5, no error pulses.
- Send 0x3C then 0xFF back-to-back with no gap → two Rx_DV_out pulses exactly 160 cycles apart, bytes 0x3C then 0xFF.
- Drive a 5-cycle low glitch on the idle line → no pulses, FSM back in IDLE, Rx_Byte_out unchanged.
- Send 0x55 with the stop bit held low → Frame_Err_out pulses once, Rx_DV_out stays 0, Rx_Byte_out keeps its previous value.
- Assert RST during data bit 4 of 0x81, then send 0x42 → no pulse for 0x81, one Rx_DV_out pulse with 0x42.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 → Rx_DV_out pulse, byte 0x07. Send 0x07 with parity 0 → Parity_Err_out pulse, no Rx_DV_out.
